// File: rtl/exa_crosb_output_vc_buffer.sv
// Per-output VC receive buffer: stores crossbar packets per VC, returns credits, drains
// complete packets round-robin. Optional per-VC drained-packet counters: EXA_VCBUF_STATS_EN.
module exa_crosb_output_vc_buffer #(
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned VC_NUM        = 2,
  parameter int unsigned PRIO_NUM      = 2,
  parameter int unsigned NVC           = VC_NUM * PRIO_NUM,
  parameter int unsigned LOG_NVC       = (NVC > 1) ? $clog2(NVC) : 1,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned MAX_PKT_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [LOG_NVC-1:0]    i_vc,
  output logic [NVC-1:0]        o_credits,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [LOG_NVC-1:0]    o_vc,
`ifdef EXA_VCBUF_STATS_EN
  output logic [NVC-1:0][15:0]  o_pkt_stats,
`endif
  output logic                  o_err_oversize
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_PKT_WORDS + 1) + 1;

  localparam logic       WR_IDLE = 1'b0;
  localparam logic       WR_PKT  = 1'b1;
  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_SEL  = 2'd1;
  localparam logic [1:0] RD_XFER = 2'd2;

  logic [DATA_WIDTH:0]   mem [NVC*FIFO_DEPTH];
  logic [AW-1:0]         wptr_q [NVC];
  logic [AW-1:0]         rptr_q [NVC];
  logic [CW-1:0]         wcnt_q [NVC];
  logic [CW-1:0]         wcnt_d [NVC];
  logic [CW-1:0]         pcnt_q [NVC];
  logic [CW-1:0]         pcnt_d [NVC];

  logic                  wr_state_q, wr_state_d;
  logic [LOG_NVC-1:0]    wr_vc_q, wr_vc_d, cur_vc;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  err_q;
  logic [NVC-1:0]        credits_q;

  logic [1:0]            rd_state_q, rd_state_d;
  logic [LOG_NVC-1:0]    last_vc_q, rd_vc_q, rr_vc, fetch_vc;
  logic                  rr_found, pend_q, pend_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q, out_valid_q;

  logic                  wr_hs, rd_hs, rd_fetch;
  logic [NVC-1:0]        wr_en, pop_en, fetch_en, pkt_inc, pkt_dec;

  // Write side: VC comes from i_vc on the first beat, from the latched wr_vc afterwards.
  assign cur_vc        = (wr_state_q == WR_PKT) ? wr_vc_q : i_vc;
  assign s_axis_tready = !reset && (wcnt_q[cur_vc] < CW'(FIFO_DEPTH));
  assign wr_hs         = s_axis_tvalid && s_axis_tready;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_vc_d    = wr_vc_q;
    beat_d     = beat_q;
    if (wr_hs) begin
      if (s_axis_tlast) begin
        wr_state_d = WR_IDLE;
        beat_d     = '0;
      end else begin
        if (wr_state_q == WR_IDLE) begin
          wr_state_d = WR_PKT;
          wr_vc_d    = i_vc;
        end
        if (beat_q < BW'(MAX_PKT_WORDS)) beat_d = beat_q + 1'b1;
      end
    end
  end

  // Read side
  assign rd_hs    = out_valid_q && m_axis_tready;
  assign rd_fetch = ((rd_state_q == RD_SEL) && rr_found) ||
                    ((rd_state_q == RD_XFER) && rd_hs && !out_last_q);
  assign fetch_vc = (rd_state_q == RD_SEL) ? rr_vc : rd_vc_q;

  always_comb begin
    logic [LOG_NVC-1:0] cand;
    rr_found = 1'b0;
    rr_vc    = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= NVC; i++) begin
      cand = LOG_NVC'((int'(last_vc_q) + i) % NVC);
      if (!rr_found && (pcnt_q[cand] != '0)) begin
        rr_found = 1'b1;
        rr_vc    = cand;
      end
    end
  end

  // The staged output word stays counted in wcnt until it is handed downstream.
  always_comb begin
    pend_q = 1'b0;
    pend_d = 1'b0;
    for (int v = 0; v < NVC; v++) begin
      wr_en[v]    = wr_hs && (cur_vc == LOG_NVC'(v));
      pkt_inc[v]  = wr_en[v] && s_axis_tlast;
      fetch_en[v] = rd_fetch && (fetch_vc == LOG_NVC'(v));
      pop_en[v]   = rd_hs && (rd_vc_q == LOG_NVC'(v));
      pkt_dec[v]  = pop_en[v] && out_last_q;
      wcnt_d[v]   = wcnt_q[v] + CW'(wr_en[v]) - CW'(pop_en[v]);
      pcnt_d[v]   = pcnt_q[v] + CW'(pkt_inc[v]) - CW'(pkt_dec[v]);
      pend_q      = pend_q | (pcnt_q[v] != '0);
      pend_d      = pend_d | (pcnt_d[v] != '0);
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (pend_q) rd_state_d = RD_SEL;
      RD_SEL:  rd_state_d = rr_found ? RD_XFER : RD_IDLE;
      RD_XFER: if (rd_hs && out_last_q) rd_state_d = pend_d ? RD_SEL : RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_hs) mem[{cur_vc, wptr_q[cur_vc]}] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NVC; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        wcnt_q[v] <= '0;
        pcnt_q[v] <= '0;
      end
      wr_state_q  <= WR_IDLE;
      wr_vc_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      credits_q   <= '0;
      rd_state_q  <= RD_IDLE;
      last_vc_q   <= '0;
      rd_vc_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        wcnt_q[v] <= wcnt_d[v];
        pcnt_q[v] <= pcnt_d[v];
        if (wr_en[v])    wptr_q[v] <= wptr_q[v] + 1'b1;
        if (fetch_en[v]) rptr_q[v] <= rptr_q[v] + 1'b1;
        credits_q[v] <= ((CW'(FIFO_DEPTH) - wcnt_d[v]) >= CW'(MAX_PKT_WORDS)) &&
                        !((wr_state_d == WR_PKT) && (wr_vc_d == LOG_NVC'(v)));
      end
      wr_state_q <= wr_state_d;
      wr_vc_q    <= wr_vc_d;
      beat_q     <= beat_d;
      if (wr_hs && (beat_q >= BW'(MAX_PKT_WORDS))) err_q <= 1'b1;
      rd_state_q <= rd_state_d;
      if ((rd_state_q == RD_SEL) && rr_found) rd_vc_q <= rr_vc;
      if (rd_hs && out_last_q) last_vc_q <= rd_vc_q;
      if (rd_fetch) begin
        out_valid_q              <= 1'b1;
        {out_last_q, out_data_q} <= mem[{fetch_vc, rptr_q[fetch_vc]}];
      end else if (rd_hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

`ifdef EXA_VCBUF_STATS_EN
  logic [NVC-1:0][15:0] stats_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stats_q <= '0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (pkt_dec[v]) stats_q[v] <= stats_q[v] + 16'd1;
      end
    end
  end

  assign o_pkt_stats = stats_q;
`endif

  assign o_credits      = credits_q;
  assign m_axis_tdata   = out_data_q;
  assign m_axis_tvalid  = out_valid_q;
  assign m_axis_tlast   = out_last_q;
  assign o_vc           = rd_vc_q;
  assign o_err_oversize = err_q;

endmodule
